// File: rtl/uart_pkg.sv
// Shared UART types: byte width and byte type used by the receiver, transmitter and buffers.
package uart_pkg;
    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO: synchronous write, asynchronous (distributed) read.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  uart_byte_t        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output uart_byte_t        rdata
);

    uart_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// FWFT receive buffer behind the UART receiver with sticky overflow flag.
// Define UART_RX_FIFO_DROP_CNT_EN to add the saturating o_drop_count output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  uart_byte_t       i_data,
    input  logic             i_data_available,
    output uart_byte_t       o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_overflow,
`ifdef UART_RX_FIFO_DROP_CNT_EN
    output logic [15:0]      o_drop_count,
`endif
    input  logic             i_clear_overflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;
    uart_byte_t        head;

    assign push  = i_data_available;
    assign pop   = o_valid & i_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en = push & (~o_full | pop);
    assign drop  = push & o_full & ~pop;

    uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (i_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (i_clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;

    // A drop coinciding with a clear restarts the tally at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (drop && i_clear_overflow) begin
            drop_count <= 16'd1;
        end else if (drop) begin
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end else if (i_clear_overflow) begin
            drop_count <= '0;
        end
    end

    assign o_drop_count = drop_count;
`endif

    // Storage is uninitialised after reset, so the head is masked while empty.
    assign o_valid    = (count != '0);
    assign o_empty    = (count == '0);
    assign o_full     = (count == FULL_CNT);
    assign o_count    = count;
    assign o_overflow = overflow;
    assign o_data     = o_valid ? head : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner cases and a random queue-model run.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_data_available;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_count;
    logic       o_full;
    logic       o_empty;
    logic       o_overflow;
    logic       i_clear_overflow;
`ifdef UART_RX_FIFO_DROP_CNT_EN
    logic [15:0] o_drop_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    bit         m_ov;
    int         m_dc;

    typedef struct {
        bit         push;
        logic [7:0] data;
        bit         ready;
        bit         clr;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_count;
        bit         e_ov;
    } vec_t;

    vec_t vecs[7];

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_data           (i_data),
        .i_data_available (i_data_available),
        .o_data           (o_data),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_count          (o_count),
        .o_full           (o_full),
        .o_empty          (o_empty),
        .o_overflow       (o_overflow),
`ifdef UART_RX_FIFO_DROP_CNT_EN
        .o_drop_count     (o_drop_count),
`endif
        .i_clear_overflow (i_clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(o_valid), 32'(q.size() != 0));
        chk("count", 32'(o_count), 32'(q.size()));
        chk("full", 32'(o_full), 32'(q.size() == DEPTH));
        chk("empty", 32'(o_empty), 32'(q.size() == 0));
        chk("overflow", 32'(o_overflow), 32'(m_ov));
        if (q.size() != 0) chk("data", 32'(o_data), 32'(q[0]));
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_count", 32'(o_drop_count), 32'(m_dc));
`endif
    endtask

    // Starts and ends at a falling edge; model follows the rising edge between.
    task automatic cycle(input bit p, input logic [7:0] d, input bit r, input bit c);
        bit do_pop;
        bit full_now;
        bit dropped;
        i_data_available = p;
        i_data           = d;
        i_ready          = r;
        i_clear_overflow = c;
        @(posedge clk);
        full_now = (q.size() == DEPTH);
        do_pop   = r && (q.size() != 0);
        dropped  = p && full_now && !do_pop;
        if (do_pop) void'(q.pop_front());
        if (p && !dropped) q.push_back(d);
        if (dropped) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (dropped && c) m_dc = 1;
        else if (dropped) m_dc = (m_dc == 65535) ? 65535 : m_dc + 1;
        else if (c) m_dc = 0;
        @(negedge clk);
        i_data_available = 1'b0;
        i_clear_overflow = 1'b0;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_count"}, 32'(o_count), 32'd0);
        chk({tag, "_empty"}, 32'(o_empty), 32'd1);
        chk({tag, "_full"}, 32'(o_full), 32'd0);
        chk({tag, "_overflow"}, 32'(o_overflow), 32'd0);
        chk({tag, "_data"}, 32'(o_data), 32'h00);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk({tag, "_drop_count"}, 32'(o_drop_count), 32'd0);
`endif
    endtask

    initial begin
        logic [7:0] last;
        int pushes;
        int pops;
        int iter;
        bit p;
        bit r;

        vecs[0] = '{1, 8'hA5, 0, 0, 1, 8'hA5, 1, 0};
        vecs[1] = '{0, 8'h00, 1, 0, 0, 8'h00, 0, 0};
        vecs[2] = '{1, 8'h3C, 1, 0, 1, 8'h3C, 1, 0};
        vecs[3] = '{1, 8'h4D, 1, 0, 1, 8'h4D, 1, 0};
        vecs[4] = '{1, 8'h5E, 0, 0, 1, 8'h4D, 2, 0};
        vecs[5] = '{0, 8'h00, 1, 0, 1, 8'h5E, 1, 0};
        vecs[6] = '{0, 8'h00, 1, 1, 0, 8'h00, 0, 0};

        rst_n = 1'b0;
        i_data = 8'h00;
        i_data_available = 1'b0;
        i_ready = 1'b0;
        i_clear_overflow = 1'b0;
        m_ov = 1'b0;
        m_dc = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");

        foreach (vecs[i]) begin
            cycle(vecs[i].push, vecs[i].data, vecs[i].ready, vecs[i].clr);
            chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vecs[i].e_count));
            chk($sformatf("vec%0d_overflow", i), 32'(o_overflow), 32'(vecs[i].e_ov));
            if (vecs[i].e_valid) chk($sformatf("vec%0d_data", i), 32'(o_data), 32'(vecs[i].e_data));
        end

        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        chk("fill_full", 32'(o_full), 32'd1);
        chk("fill_count", 32'(o_count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain_byte%0d", i), 32'(o_data), 32'(i));
            chk($sformatf("drain_valid%0d", i), 32'(o_valid), 32'd1);
            cycle(0, 8'h00, 1, 0);
        end
        chk("drain_empty", 32'(o_empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        cycle(1, 8'h55, 0, 0);
        chk("drop_overflow", 32'(o_overflow), 32'd1);
        chk("drop_head", 32'(o_data), 32'h00);
        chk("drop_count16", 32'(o_count), 32'd16);
`ifdef UART_RX_FIFO_DROP_CNT_EN
        chk("drop_cnt_one", 32'(o_drop_count), 32'd1);
`endif
        cycle(0, 8'h00, 0, 1);
        chk("clear_overflow", 32'(o_overflow), 32'd0);
        cycle(1, 8'h66, 0, 1);
        chk("set_beats_clear", 32'(o_overflow), 32'd1);
        cycle(0, 8'h00, 0, 1);

        cycle(1, 8'h77, 1, 0);
        chk("fullpp_count", 32'(o_count), 32'd16);
        chk("fullpp_overflow", 32'(o_overflow), 32'd0);
        chk("fullpp_head", 32'(o_data), 32'h01);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = o_data;
            cycle(0, 8'h00, 1, 0);
        end
        chk("fullpp_last", 32'(last), 32'h77);

        for (int i = 0; i < 5; i++) cycle(1, 8'hC0 + 8'(i), 0, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        q.delete();
        m_ov = 1'b0;
        m_dc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 8'h00, 1, 0);
            chk("after_reset_idle", 32'(o_valid), 32'd0);
        end
        cycle(1, 8'h9E, 0, 0);
        chk("after_reset_push", 32'(o_data), 32'h9E);

        while (q.size() < 8) cycle(1, 8'($urandom), 0, 0);
        pushes = 0;
        pops = 0;
        iter = 0;
        while ((pushes < 40 || pops < 40) && iter < 2000) begin
            p = (q.size() < 15) && (pushes < 40) && ($urandom_range(0, 1) == 1);
            r = (q.size() > 1) && (pops < 40) && ($urandom_range(0, 1) == 1);
            if (p) pushes++;
            if (r) pops++;
            cycle(p, 8'($urandom), r, $urandom_range(0, 15) == 0);
            iter++;
        end
        chk("random_budget", 32'(iter < 2000), 32'd1);
        iter = 0;
        while (q.size() != 0 && iter < 40) begin
            cycle(0, 8'h00, 1, 0);
            iter++;
        end
        chk("random_drained", 32'(o_empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
